damage_scheduler: RTL and testbench
===================================

// Module: damage_scheduler
// PURPOSE
//  Owns the character health register and sequences all health changes. Arbitrates
//  hit requests from N_SRC damage sources (boss contact, projectiles, hazards)
//  round-robin and applies invulnerability frames after each hit. Signals death.
//  Sits between collision detectors and the HUD heart renderer (current_health feeds it).
// PARAMETERS
//  N_SRC           4   number of damage requesters (1..8)
//  MAX_HP          10  health ceiling; load value clamped to this
//  COOLDOWN_FRAMES 60  invulnerability length in frame_tick pulses (1..255)
// PORTS
//  clk             in   1        system clock (65 MHz pixel clock)
//  rst             in   1        async, active-high reset
//  frame_tick      in   1        1-cycle pulse per video frame
//  game_start      in   1        level-sensitive; reload health, restart
//  game_active     in   2        ==1 means gameplay running; other values = paused/menu
//  char_hp         in   4        initial health loaded on game_start
//  hit_req         in   N_SRC    per-source level request, held until acked
//  hit_dmg         in   2*N_SRC  per-source damage amount, slice [2i+1:2i], 0 treated as 1
//  hit_ack         out  N_SRC    registered 1-cycle ack pulse
//  current_health  out  4        health value to HUD
//  invuln          out  1        high while invulnerability cooldown runs
//  char_dead       out  1        1-cycle pulse when health reaches 0
// BEHAVIOUR
//  Reset: state=IDLE, current_health=0, hit_ack=0, invuln=0, char_dead=0, cooldown=0, rr_ptr=0.
//  States: IDLE, ALIVE, INVULN, DEAD. game_start=1 overrides all, from any state:
//   current_health<=min(char_hp,MAX_HP), cooldown<=0, rr_ptr<=0, no acks, next=ALIVE
//   (char_hp=0 -> DEAD, no char_dead pulse).
//  ALIVE, game_active==1, any unmasked hit_req: grant first set req at/after rr_ptr;
//   next cycle hit_ack[g]=1, rr_ptr<=g+1 (wrap N_SRC-1->0),
//   health<=sat0(health-dmg).
//   Result 0 -> DEAD + char_dead pulse; else -> INVULN, cooldown<=COOLDOWN_FRAMES.
//  ALIVE, game_active!=1: no grants; requests stay pending.
//  INVULN: every unmasked asserted req acked next cycle and discarded (no damage).
//   Cooldown decrements on frame_tick only when game_active==1 (pause freezes it).
//   Cooldown reaching 0 -> ALIVE.
//  DEAD: asserted reqs acked and discarded; leaves only via game_start.
//  Ack masking: a source acked at cycle t is ignored at cycle t+1; req must drop on seeing ack.
//  Latency: req sampled at edge t -> hit_ack and health update visible after edge t+1.
//  invuln = (state==INVULN), registered. Health arithmetic 5-bit, saturate at 0 and MAX_HP.
//  Simultaneous frame_tick and req in INVULN: both handled the same cycle.
//  Cooldown hitting 0 with a req pending: req is served in ALIVE on the next cycle.
// CONFIGURATION
//  DMG_HEAL_EN defined: adds ports heal_req (in, 1) and heal_ack (out, 1).
//   In ALIVE/INVULN a heal is granted only in cycles with no hit grant:
//   health<=min(health+1,MAX_HP), heal_ack pulses next cycle, state unchanged.
//   Heal ignored in IDLE/DEAD (no ack) and while game_active!=1.
//  Undefined: heal ports absent; health changes only via hits and game_start.
// STRUCTURE
//  game_pkg: typedef enum dmg_state_t {IDLE,ALIVE,INVULN,DEAD}; localparam HP_W=4;
//   localparam DMG_W=2.
//  Sub-module rr_arbiter #(N): req, ptr -> one-hot grant, combinational.
//  Top holds FSM, cooldown counter, health register, ack/mask registers.
// TESTING
//  1 reset, game_start with char_hp=5 -> current_health=5, state ALIVE, no ack.
//  2 hit_req[0] held, dmg=2 -> hit_ack[0] one cycle later, health 3, invuln=1;
//    after 60 active frame_ticks invuln=0.
//  3 hit_req=4'b1111 in ALIVE, rr_ptr=2 -> src 2 granted;
//    rest acked and dropped during INVULN; health -1 only.
//  4 health=1, hit dmg=3 -> health 0 (no wrap), char_dead one pulse, DEAD;
//    further reqs acked, health stays 0.
//  5 INVULN, game_active=2 for 100 ticks -> cooldown frozen;
//    game_start mid-INVULN -> health reload, invuln=0 next cycle.
//  6 DMG_HEAL_EN, health=10, heal_req -> heal_ack, health stays 10;
//    heal and hit same cycle -> only hit acked.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the damage scheduler.
// Health arithmetic helper saturates at zero with a 5-bit intermediate.
package game_pkg;

    typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} dmg_state_t;

    localparam int HP_W  = 4;
    localparam int DMG_W = 2;

    // A damage field of 0 still costs one heart.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [DMG_W-1:0] dmg);
        logic [DMG_W-1:0] eff;
        logic [HP_W:0]    diff;
        eff  = (dmg == '0) ? DMG_W'(1) : dmg;
        diff = {1'b0, hp} - (HP_W + 1)'(eff);
        return diff[HP_W] ? '0 : diff[HP_W-1:0];
    endfunction

endpackage

// File: rtl/damage_scheduler_if.sv
// Hit request/ack bus between collision detectors (master) and the scheduler (slave).
// Define DMG_HEAL_EN to add the heal_req/heal_ack pair.
interface damage_scheduler_if #(
    parameter int N_SRC = 4
);
    import game_pkg::*;

    logic [N_SRC-1:0]       hit_req;
    logic [DMG_W*N_SRC-1:0] hit_dmg;
    logic [N_SRC-1:0]       hit_ack;

`ifdef DMG_HEAL_EN
    logic heal_req;
    logic heal_ack;

    modport master (output hit_req, hit_dmg, heal_req, input hit_ack, heal_ack);
    modport slave  (input hit_req, hit_dmg, heal_req, output hit_ack, heal_ack);
`else
    modport master (output hit_req, hit_dmg, input hit_ack);
    modport slave  (input hit_req, hit_dmg, output hit_ack);
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or after ptr.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/damage_scheduler.sv
// Health owner: round-robin hit arbitration, invulnerability cooldown and death pulse.
// Define DMG_HEAL_EN to enable the heal handshake on the bus interface.
module damage_scheduler
    import game_pkg::*;
#(
    parameter int N_SRC           = 4,
    parameter int MAX_HP          = 10,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              game_start,
    input  logic [1:0]        game_active,
    input  logic [HP_W-1:0]   char_hp,
    damage_scheduler_if.slave bus,
    output logic [HP_W-1:0]   current_health,
    output logic              invuln,
    output logic              char_dead
);

    localparam int              PTR_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);
    localparam logic [7:0]      CD_INIT  = 8'(COOLDOWN_FRAMES);

    dmg_state_t       state_q, state_d;
    logic [HP_W-1:0]  health_q, health_d;
    logic [7:0]       cooldown_q, cooldown_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_SRC-1:0] ack_q, ack_d;
    logic             dead_q, dead_d;

    logic             run, hit_go, cd_tick, cd_done;
    logic [N_SRC-1:0] pending, grant;
    logic [PTR_W-1:0] grant_idx;
    logic [DMG_W-1:0] grant_dmg;
    logic [HP_W-1:0]  load_hp, hit_hp;

    // A source acked last cycle is still holding its request; mask it out.
    assign pending = bus.hit_req & ~ack_q;
    assign run     = (game_active == 2'd1);
    assign hit_go  = (state_q == ALIVE) && run && (|pending);
    assign cd_tick = (state_q == INVULN) && run && frame_tick;
    assign cd_done = cd_tick && (cooldown_q <= 8'd1);
    assign load_hp = (char_hp > MAX_HP_V) ? MAX_HP_V : char_hp;
    assign hit_hp  = sat_sub(health_q, grant_dmg);

    rr_arbiter #(.N(N_SRC)) u_arb (
        .req   (pending),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        grant_dmg = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                grant_dmg = bus.hit_dmg[DMG_W*i +: DMG_W];
            end
        end
    end

`ifdef DMG_HEAL_EN
    logic heal_ack_q, heal_ack_d, heal_go;
    assign heal_go = bus.heal_req && !heal_ack_q && run && !hit_go &&
                     ((state_q == ALIVE) || (state_q == INVULN));
    assign bus.heal_ack = heal_ack_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (game_start) begin
            state_d = (load_hp == '0) ? DEAD : ALIVE;
        end else begin
            case (state_q)
                ALIVE:   if (hit_go) state_d = (hit_hp == '0) ? DEAD : INVULN;
                INVULN:  if (cd_done) state_d = ALIVE;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        health_d   = health_q;
        cooldown_d = cooldown_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        dead_d     = 1'b0;
`ifdef DMG_HEAL_EN
        heal_ack_d = 1'b0;
`endif
        if (game_start) begin
            health_d   = load_hp;
            cooldown_d = '0;
            rr_ptr_d   = '0;
        end else begin
            case (state_q)
                ALIVE: if (hit_go) begin
                    ack_d      = grant;
                    health_d   = hit_hp;
                    dead_d     = (hit_hp == '0);
                    cooldown_d = CD_INIT;
                    rr_ptr_d   = (grant_idx == PTR_W'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
                end
                INVULN: begin
                    // On the expiring tick requests stay pending for ALIVE to serve.
                    if (!cd_done) ack_d = pending;
                    if (cd_tick) cooldown_d = (cooldown_q != '0) ? cooldown_q - 8'd1 : '0;
                end
                DEAD:    ack_d = pending;
                default: ack_d = '0;
            endcase
`ifdef DMG_HEAL_EN
            if (heal_go) begin
                health_d   = (health_q >= MAX_HP_V) ? MAX_HP_V : health_q + 1'b1;
                heal_ack_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            health_q   <= '0;
            cooldown_q <= '0;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            dead_q     <= 1'b0;
`ifdef DMG_HEAL_EN
            heal_ack_q <= 1'b0;
`endif
        end else begin
            health_q   <= health_d;
            cooldown_q <= cooldown_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            dead_q     <= dead_d;
`ifdef DMG_HEAL_EN
            heal_ack_q <= heal_ack_d;
`endif
        end
    end

    always_comb begin
        invuln         = (state_q == INVULN);
        current_health = health_q;
        char_dead      = dead_q;
    end

    assign bus.hit_ack = ack_q;

endmodule

// File: tb/tb_damage_scheduler.sv
// Directed vector table plus randomized traffic against a behavioural health model.
module tb_damage_scheduler;

    localparam int N     = 4;
    localparam int MAXHP = 10;
    localparam int CD    = 60;

    localparam int MD_IDLE   = 0;
    localparam int MD_ALIVE  = 1;
    localparam int MD_INVULN = 2;
    localparam int MD_DEAD   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick, game_start;
    logic [1:0] game_active;
    logic [3:0] char_hp;
    logic [3:0] current_health;
    logic       invuln, char_dead;
    bit         heal_drv;

    damage_scheduler_if #(.N_SRC(N)) bus_if ();

`ifdef DMG_HEAL_EN
    assign bus_if.heal_req = heal_drv;
`endif

    damage_scheduler #(.N_SRC(N), .MAX_HP(MAXHP), .COOLDOWN_FRAMES(CD)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .game_start     (game_start),
        .game_active    (game_active),
        .char_hp        (char_hp),
        .bus            (bus_if),
        .current_health (current_health),
        .invuln         (invuln),
        .char_dead      (char_dead)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input bit gs, input bit [1:0] ga, input bit ft, input bit [3:0] hp,
                         input bit [3:0] req, input bit [7:0] dmg, input bit heal);
        game_start     = gs;
        game_active    = ga;
        frame_tick     = ft;
        char_hp        = hp;
        bus_if.hit_req = req;
        bus_if.hit_dmg = dmg;
        heal_drv       = heal;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int     m_mode = MD_IDLE, m_hp = 0, m_cd = 0, m_ptr = 0;
    bit [3:0] m_ack = '0;
    bit     m_dead = 1'b0, m_heal_ack = 1'b0;

    task automatic model_step(input bit gs, input bit [1:0] ga, input bit ft, input bit [3:0] hp_in,
                              input bit [3:0] req, input bit [7:0] dmg, input bit heal);
        bit [3:0] live, nack;
        bit       granted, heal_live;
        int       s, d, mode0;
        live      = req & ~m_ack;
        heal_live = heal && !m_heal_ack;
        nack      = '0;
        granted   = 1'b0;
        mode0     = m_mode;
        m_dead     = 1'b0;
        m_heal_ack = 1'b0;
        if (gs) begin
            m_hp   = (int'(hp_in) > MAXHP) ? MAXHP : int'(hp_in);
            m_cd   = 0;
            m_ptr  = 0;
            m_mode = (m_hp == 0) ? MD_DEAD : MD_ALIVE;
        end else begin
            if (m_mode == MD_ALIVE && ga == 2'd1 && live != 0) begin
                for (int k = 0; k < N; k++) begin
                    s = (m_ptr + k) % N;
                    if (!granted && live[s]) begin
                        granted = 1'b1;
                        d = int'(dmg[2*s +: 2]);
                        if (d == 0) d = 1;
                        m_hp    = (m_hp > d) ? m_hp - d : 0;
                        nack[s] = 1'b1;
                        m_ptr   = (s + 1) % N;
                    end
                end
                if (m_hp == 0) begin
                    m_mode = MD_DEAD;
                    m_dead = 1'b1;
                end else begin
                    m_mode = MD_INVULN;
                    m_cd   = CD;
                end
            end else if (m_mode == MD_INVULN) begin
                if (ft && ga == 2'd1 && m_cd == 1) begin
                    m_cd   = 0;
                    m_mode = MD_ALIVE;
                end else begin
                    nack = live;
                    if (ft && ga == 2'd1) m_cd = m_cd - 1;
                end
            end else if (m_mode == MD_DEAD) begin
                nack = live;
            end
`ifdef DMG_HEAL_EN
            if (heal_live && ga == 2'd1 && !granted && (mode0 == MD_ALIVE || mode0 == MD_INVULN)) begin
                m_hp       = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
                m_heal_ack = 1'b1;
            end
`endif
        end
        m_ack = nack;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " ack"}, bus_if.hit_ack, m_ack);
        check({tag, " health"}, current_health, m_hp);
        check({tag, " invuln"}, invuln, m_mode == MD_INVULN);
        check({tag, " dead"}, char_dead, m_dead);
`ifdef DMG_HEAL_EN
        check({tag, " heal_ack"}, bus_if.heal_ack, m_heal_ack);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int       rep;
        bit       gs;
        bit [1:0] ga;
        bit       ft;
        bit [3:0] hp;
        bit [3:0] req;
        bit [7:0] dmg;
        bit [3:0] e_ack;
        bit [3:0] e_hp;
        bit       e_inv;
        bit       e_dead;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rep, input bit gs, input bit [1:0] ga, input bit ft, input bit [3:0] hp,
                       input bit [3:0] req, input bit [7:0] dmg, input bit [3:0] e_ack,
                       input bit [3:0] e_hp, input bit e_inv, input bit e_dead);
        vec_t v;
        v.rep = rep; v.gs = gs; v.ga = ga; v.ft = ft; v.hp = hp; v.req = req; v.dmg = dmg;
        v.e_ack = e_ack; v.e_hp = e_hp; v.e_inv = e_inv; v.e_dead = e_dead;
        vecs.push_back(v);
    endtask

    bit [3:0] rq;
    bit [7:0] dm;
    bit       hl;

    initial begin
        //  rep gs ga ft hp  req      dmg     ack      hp inv dead
        add(1,   0, 1, 0, 0,  4'b1111, 8'h00,  4'b0000, 0, 0, 0); // IDLE ignores requests
        add(1,   1, 1, 0, 5,  4'b0000, 8'h00,  4'b0000, 5, 0, 0); // start with 5
        add(1,   0, 1, 0, 0,  4'b0001, 8'h02,  4'b0001, 3, 1, 0); // src0 dmg 2
        add(1,   0, 1, 0, 0,  4'b0001, 8'h02,  4'b0000, 3, 1, 0); // masked while ack visible
        add(59,  0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 3, 1, 0);
        add(1,   0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 3, 0, 0); // 60th tick ends cooldown
        add(1,   0, 1, 0, 0,  4'b0010, 8'h00,  4'b0010, 2, 1, 0); // dmg 0 counts as 1
        add(1,   0, 1, 0, 0,  4'b0010, 8'h00,  4'b0000, 2, 1, 0);
        add(59,  0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 2, 1, 0);
        add(1,   0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 2, 0, 0);
        add(1,   0, 1, 0, 0,  4'b1111, 8'h55,  4'b0100, 1, 1, 0); // rr_ptr=2 picks src2
        add(1,   0, 1, 0, 0,  4'b1111, 8'h55,  4'b1011, 1, 1, 0); // others discarded
        add(1,   0, 1, 0, 0,  4'b1011, 8'h55,  4'b0000, 1, 1, 0);
        add(1,   0, 1, 0, 0,  4'b0000, 8'h00,  4'b0000, 1, 1, 0);
        add(59,  0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 1, 1, 0);
        add(1,   0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 1, 0, 0);
        add(1,   0, 1, 0, 0,  4'b1000, 8'hC0,  4'b1000, 0, 0, 1); // overkill saturates at 0
        add(1,   0, 1, 0, 0,  4'b1000, 8'hC0,  4'b0000, 0, 0, 0); // single death pulse
        add(1,   0, 1, 0, 0,  4'b0001, 8'h03,  4'b0001, 0, 0, 0); // DEAD acks
        add(1,   0, 1, 0, 0,  4'b0001, 8'h03,  4'b0000, 0, 0, 0);
        add(1,   1, 1, 0, 12, 4'b0000, 8'h00,  4'b0000, 10, 0, 0); // load clamped
        add(1,   0, 1, 0, 0,  4'b0001, 8'h01,  4'b0001, 9, 1, 0);
        add(100, 0, 2, 1, 0,  4'b0000, 8'h00,  4'b0000, 9, 1, 0); // paused: cooldown frozen
        add(59,  0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 9, 1, 0);
        add(1,   1, 1, 0, 7,  4'b0000, 8'h00,  4'b0000, 7, 0, 0); // restart mid-INVULN
        add(1,   0, 1, 0, 0,  4'b0000, 8'h00,  4'b0000, 7, 0, 0);
        add(3,   0, 2, 0, 0,  4'b0001, 8'h01,  4'b0000, 7, 0, 0); // paused ALIVE holds req
        add(1,   0, 1, 0, 0,  4'b0001, 8'h01,  4'b0001, 6, 1, 0);
        add(1,   1, 1, 0, 0,  4'b0000, 8'h00,  4'b0000, 0, 0, 0); // hp 0 -> DEAD, no pulse
        add(1,   0, 1, 0, 0,  4'b0010, 8'h00,  4'b0010, 0, 0, 0);
        add(1,   0, 1, 0, 0,  4'b0000, 8'h00,  4'b0000, 0, 0, 0);
        add(1,   1, 1, 0, 4,  4'b0000, 8'h00,  4'b0000, 4, 0, 0);
        add(1,   0, 1, 0, 0,  4'b0100, 8'h10,  4'b0100, 3, 1, 0);
        add(58,  0, 1, 1, 0,  4'b0000, 8'h00,  4'b0000, 3, 1, 0);
        add(1,   0, 1, 1, 0,  4'b1000, 8'h00,  4'b1000, 3, 1, 0); // tick and req same cycle
        add(1,   0, 1, 1, 0,  4'b1001, 8'h01,  4'b0000, 3, 0, 0); // expiry leaves src0 pending
        add(1,   0, 1, 0, 0,  4'b0001, 8'h01,  4'b0001, 2, 1, 0); // served in ALIVE

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", bus_if.hit_ack, 4'b0000);
        check("reset health", current_health, 4'd0);
        check("reset invuln", invuln, 1'b0);
        check("reset dead", char_dead, 1'b0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            for (int r = 0; r < vecs[v].rep; r++) begin
                drive(vecs[v].gs, vecs[v].ga, vecs[v].ft, vecs[v].hp, vecs[v].req, vecs[v].dmg, 1'b0);
                tick();
            end
            check($sformatf("v%0d ack", v), bus_if.hit_ack, vecs[v].e_ack);
            check($sformatf("v%0d health", v), current_health, vecs[v].e_hp);
            check($sformatf("v%0d invuln", v), invuln, vecs[v].e_inv);
            check($sformatf("v%0d dead", v), char_dead, vecs[v].e_dead);
        end

`ifdef DMG_HEAL_EN
        drive(1, 1, 0, 10, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0, 1); tick();
        check("heal at max ack", bus_if.heal_ack, 1'b1);
        check("heal at max hp", current_health, 4'd10);
        drive(0, 1, 0, 0, 0, 0, 1); tick();
        check("heal masked", bus_if.heal_ack, 1'b0);
        drive(0, 1, 0, 0, 4'b0001, 8'h02, 1); tick();
        check("heal+hit ack", bus_if.hit_ack, 4'b0001);
        check("heal+hit heal_ack", bus_if.heal_ack, 1'b0);
        check("heal+hit hp", current_health, 4'd8);
        drive(0, 1, 0, 0, 4'b0001, 8'h02, 1); tick();
        check("heal invuln ack", bus_if.heal_ack, 1'b1);
        check("heal invuln hp", current_health, 4'd9);
        drive(0, 1, 0, 0, 0, 0, 0); tick();
`endif

        // Randomized traffic; requesters hold until acked, then drop.
        rq = '0;
        dm = '0;
        hl = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(0, 5) == 0) begin
                    rq[i]        = 1'b1;
                    dm[2*i +: 2] = 2'($urandom_range(0, 3));
                end
            end
`ifdef DMG_HEAL_EN
            if (!hl && $urandom_range(0, 3) == 0) hl = 1'b1;
`endif
            drive((c == 0) || ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 9) < 8) ? 2'd1 : 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), rq, dm, hl);
            @(posedge clk);
            model_step(game_start, game_active, frame_tick, char_hp, rq, dm, hl);
            #1;
            compare_model($sformatf("rnd%0d", c));
            rq = rq & ~bus_if.hit_ack;
`ifdef DMG_HEAL_EN
            if (bus_if.heal_ack) hl = 1'b0;
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
